// File: rtl/attention_score_engine.sv
// attention_score_engine: sequential Q·K scorer with shared MAC, saturated scaled scores and running max.
module attention_score_engine #(
  parameter int DATA_W = 32,
  parameter int DIM = 6,
  parameter int NUM_KEYS = 4,
  parameter int SHIFT_AMOUNT = 2,
  parameter int OUT_W = 64,
  parameter logic signed [OUT_W-1:0] LINEAR_NORM = '0,
  localparam int IDX_W = $clog2(NUM_KEYS > 1 ? NUM_KEYS : 2)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    q_valid,
  output logic                    q_ready,
  input  logic [DIM*DATA_W-1:0]   q_data,
  input  logic                    k_valid,
  output logic                    k_ready,
  input  logic [DIM*DATA_W-1:0]   k_data,
  output logic                    score_valid,
  input  logic                    score_ready,
  output logic [OUT_W-1:0]        score,
  output logic [IDX_W-1:0]        score_idx,
  output logic                    score_last,
  output logic [OUT_W-1:0]        max_score,
  output logic [IDX_W-1:0]        max_idx
);
  localparam int PW = 2*DATA_W;
  localparam int ACC_W = PW + $clog2(DIM) + 1;
  localparam int SW = (ACC_W > OUT_W ? ACC_W : OUT_W) + 1;
  localparam int EW = $clog2(DIM > 1 ? DIM : 2);
  localparam logic signed [OUT_W-1:0] S_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] S_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD_K, MAC, EMIT} state_t;
  state_t state, state_n;

  logic [DIM*DATA_W-1:0] q_reg, q_sh, k_sh;
  logic signed [ACC_W-1:0] acc, acc_n;
  logic signed [PW-1:0] prod;
  logic signed [SW-1:0] s;
  logic signed [OUT_W-1:0] score_n;
  logic [EW-1:0] elem_cnt;
  logic [IDX_W-1:0] key_cnt;
  logic mac_done;

  assign q_ready = state == IDLE;
  assign k_ready = state == LOAD_K;
  assign score_valid = state == EMIT;

  // Working copies shift down one element per MAC cycle so element 0 always feeds the multiplier.
  always_comb begin
    prod = PW'($signed(q_sh[DATA_W-1:0])) * PW'($signed(k_sh[DATA_W-1:0]));
    acc_n = acc + ACC_W'(prod);
    mac_done = elem_cnt == EW'(DIM-1);
    s = SW'(acc_n >>> SHIFT_AMOUNT) + SW'(LINEAR_NORM);
    score_n = s > SW'(S_MAX) ? S_MAX : s < SW'(S_MIN) ? S_MIN : s[OUT_W-1:0];
  end

  always_comb begin
    state_n = flush ? IDLE :
              state == IDLE   ? (q_valid ? LOAD_K : IDLE) :
              state == LOAD_K ? (k_valid ? MAC : LOAD_K) :
              state == MAC    ? (mac_done ? EMIT : MAC) :
              (score_ready ? (score_last ? IDLE : LOAD_K) : EMIT);
  end

  always_ff @(posedge clk) state <= rst ? IDLE : state_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg <= '0;
      q_sh <= '0;
      k_sh <= '0;
      acc <= '0;
      elem_cnt <= '0;
      key_cnt <= '0;
      score <= '0;
      score_idx <= '0;
      score_last <= 1'b0;
      max_score <= '0;
      max_idx <= '0;
    end else if (flush) begin
      acc <= '0;
      elem_cnt <= '0;
      key_cnt <= '0;
    end else begin
      if (state == IDLE && q_valid) begin
        q_reg <= q_data;
        key_cnt <= '0;
      end
      if (state == LOAD_K && k_valid) begin
        q_sh <= q_reg;
        k_sh <= k_data;
        acc <= '0;
        elem_cnt <= '0;
      end
      if (state == MAC) begin
        acc <= acc_n;
        elem_cnt <= elem_cnt + 1'b1;
        q_sh <= q_sh >> DATA_W;
        k_sh <= k_sh >> DATA_W;
        if (mac_done) begin
          score <= score_n;
          score_idx <= key_cnt;
          score_last <= key_cnt == IDX_W'(NUM_KEYS-1);
          if (key_cnt == '0 || score_n > $signed(max_score)) begin
            max_score <= score_n;
            max_idx <= key_cnt;
          end
        end
      end
      if (state == EMIT && score_ready && !score_last) key_cnt <= key_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_attention_score_engine.sv
// tb_attention_score_engine: directed and random queries on three LINEAR_NORM variants against a behavioural model.
module tb_attention_score_engine;
  localparam int W = 32;
  localparam int D = 6;
  localparam int N = 4;
  typedef logic [D*W-1:0] vec_t;

  function automatic logic [63:0] ln_of(input int g);
    return g == 1 ? 64'h4000_0000_0000_0000 : g == 2 ? 64'h8000_0000_0000_0000 : 64'h0;
  endfunction

  logic clk = 0;
  logic rst, flush, q_valid, k_valid, score_ready;
  vec_t q_data, k_data;
  logic qr[3], kr[3], sv[3], sl[3];
  logic [63:0] sc[3], mx[3];
  logic [1:0] si[3], mi[3];
  int checks = 0;
  int errors = 0;
  vec_t keys[N];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    attention_score_engine #(.LINEAR_NORM(ln_of(g))) u_dut (
      .clk(clk), .rst(rst), .flush(flush),
      .q_valid(q_valid), .q_ready(qr[g]), .q_data(q_data),
      .k_valid(k_valid), .k_ready(kr[g]), .k_data(k_data),
      .score_valid(sv[g]), .score_ready(score_ready), .score(sc[g]),
      .score_idx(si[g]), .score_last(sl[g]), .max_score(mx[g]), .max_idx(mi[g])
    );
  end

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Dot product in wide plain arithmetic, floor shift by 2, bias, clamp to 64-bit signed.
  function automatic logic [63:0] model(input vec_t q, input vec_t k, input logic [63:0] ln);
    logic signed [127:0] a, qi, ki, mxv, mnv;
    a = '0;
    for (int i = 0; i < D; i++) begin
      qi = $signed(q[i*W +: W]);
      ki = $signed(k[i*W +: W]);
      a += qi * ki;
    end
    a = (a >>> 2) + $signed(ln);
    mxv = $signed(64'h7FFF_FFFF_FFFF_FFFF);
    mnv = $signed(64'h8000_0000_0000_0000);
    return a > mxv ? mxv[63:0] : a < mnv ? mnv[63:0] : a[63:0];
  endfunction

  function automatic vec_t splat(input logic [31:0] v);
    return {D{v}};
  endfunction

  // abort_mode 1: flush in 3rd MAC cycle of abort_key; 2: rst while abort_key's score is pending.
  task automatic run_query(input vec_t q, input int hold_key, input int hold_n,
                           input int abort_key, input int abort_mode);
    int n;
    logic [63:0] ex[3];
    logic [63:0] bm[3];
    int bi[3];
    q_valid = 1;
    q_data = q;
    n = 0;
    while (!qr[0] && n < 50) begin tick; n++; end
    tick;
    q_valid = 0;
    q_data = ~q;
    chk("k_ready_after_q", 64'(kr[0]), 64'd1);
    for (int j = 0; j < N; j++) begin
      k_valid = 1;
      k_data = keys[j];
      n = 0;
      while (!kr[0] && n < 50) begin tick; n++; end
      tick;
      k_valid = 0;
      k_data = ~keys[j];
      if (abort_mode == 1 && j == abort_key) begin
        tick;
        tick;
        flush = 1;
        tick;
        flush = 0;
        chk("flush_idle", {61'd0, qr[0], kr[0], sv[0]}, 64'd4);
        return;
      end
      n = 1;
      while (!sv[0] && n < 50) begin tick; n++; end
      chk($sformatf("latency k%0d", j), 64'(n), 64'd7);
      if (abort_mode == 2 && j == abort_key) begin
        rst = 1;
        tick;
        rst = 0;
        chk("rst_idle", {61'd0, qr[0], kr[0], sv[0]}, 64'd4);
        chk("rst_score", sc[0], 64'd0);
        chk("rst_max", mx[0], 64'd0);
        return;
      end
      for (int g = 0; g < 3; g++) begin
        ex[g] = model(q, keys[j], ln_of(g));
        if (j == 0 || $signed(ex[g]) > $signed(bm[g])) begin
          bm[g] = ex[g];
          bi[g] = j;
        end
        chk($sformatf("score g%0d k%0d", g, j), sc[g], ex[g]);
        chk($sformatf("idx g%0d k%0d", g, j), 64'(si[g]), 64'(j));
        chk($sformatf("last g%0d k%0d", g, j), 64'(sl[g]), 64'(j == N-1));
        if (j == N-1) begin
          chk($sformatf("max_score g%0d", g), mx[g], bm[g]);
          chk($sformatf("max_idx g%0d", g), 64'(mi[g]), 64'(bi[g]));
        end
      end
      if (j == hold_key) begin
        for (int h = 0; h < hold_n; h++) begin
          tick;
          chk("hold_ctl", {60'd0, kr[0], sv[0], si[0]}, {60'd0, 1'b0, 1'b1, 2'(j)});
          chk("hold_score", sc[0], ex[0]);
          if (j == N-1) chk("hold_max", {mx[0][61:0], mi[0]}, {bm[0][61:0], 2'(bi[0])});
        end
      end
      score_ready = 1;
      tick;
      score_ready = 0;
      if (j < N-1) chk("k_ready_after_score", {62'd0, kr[0], sv[0]}, 64'd2);
      else chk("q_ready_after_last", {62'd0, qr[0], sv[0]}, 64'd2);
    end
  endtask

  task automatic rand_keys;
    for (int j = 0; j < N; j++)
      for (int i = 0; i < D; i++) keys[j][i*W +: W] = $urandom;
  endtask

  function automatic vec_t rand_vec;
    vec_t v;
    for (int i = 0; i < D; i++) v[i*W +: W] = $urandom;
    return v;
  endfunction

  initial begin
    rst = 1;
    flush = 0;
    q_valid = 0;
    k_valid = 0;
    score_ready = 0;
    q_data = '0;
    k_data = '0;
    tick;
    tick;
    rst = 0;
    chk("reset_ctl", {61'd0, qr[0], kr[0], sv[0]}, 64'd4);
    chk("reset_score", sc[0], 64'd0);
    chk("reset_max", mx[0], 64'd0);
    chk("reset_idx", {59'd0, si[0], mi[0], sl[0]}, 64'd0);

    keys[0] = splat(32'd1);
    keys[1] = splat(32'hFFFF_FFFF);
    keys[2] = splat(32'd1);
    keys[3] = splat(32'hFFFF_FFFF);
    run_query({32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1}, -1, 0, -1, 0);

    keys[0] = 192'd12;
    keys[1] = 192'd36;
    keys[2] = 192'd36;
    keys[3] = 192'd8;
    run_query(192'd1, 3, 10, -1, 0);

    keys[0] = splat(32'h8000_0000);
    keys[1] = splat(32'h7FFF_FFFF);
    keys[2] = rand_vec();
    keys[3] = splat(32'h8000_0000);
    run_query(splat(32'h8000_0000), 1, 3, -1, 0);

    rand_keys();
    run_query(rand_vec(), -1, 0, 2, 1);
    keys[0] = splat(32'd3);
    run_query(splat(32'd2), 0, 2, -1, 0);

    rand_keys();
    run_query(rand_vec(), -1, 0, 1, 2);
    rand_keys();
    run_query(rand_vec(), -1, 0, -1, 0);

    for (int r = 0; r < 5; r++) begin
      rand_keys();
      run_query(rand_vec(), $urandom_range(0, N-1), $urandom_range(0, 3), -1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
